crc2: RTL and testbench

- Byte-serial CRC-32 engine with two run-time selectable algorithms:
  - crc_mode=0: CRC-32/IEEE 802.3 (reflected, final XOR).
  - crc_mode=1: CRC-32/MPEG-2 (non-reflected, no final XOR).
- Absorbs one byte per clock while crc_en is high; the running CRC is continuously visible on crc_out.
- Sits beside a byte-stream datapath (framer/checker); clc restarts the accumulator between messages.

---
 rtl/crc2_pkg.sv | 22 ++
 rtl/crc32_byte_step.sv | 36 +++
 rtl/crc2.sv | 46 ++++
 tb/tb_crc2.sv | 122 ++++++++++++
 4 files changed

// File: rtl/crc2_pkg.sv
// rtl/crc2_pkg.sv - shared constants, mode enum and bit-reverse helper for the CRC-32 engine
package crc2_pkg;

    localparam logic [31:0] CRC_POLY_NORM = 32'h04C11DB7;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT    = 32'hFFFFFFFF;

    typedef enum logic {
        CRC_IEEE_REFL = 1'b0,
        CRC_MPEG2     = 1'b1
    } crc_mode_e;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// rtl/crc32_byte_step.sv - one byte of CRC-32 LFSR advance, reflected or normal bit order
module crc32_byte_step
    import crc2_pkg::*;
#(
    parameter logic [31:0] POLY = CRC_POLY_NORM
) (
    input  logic [31:0] acc,
    input  logic [7:0]  d,
    input  logic        reflect,
    output logic [31:0] nxt
);

    localparam logic [31:0] POLY_REFL = bit_reverse32(POLY);

    logic [31:0] w_c;
    logic        w_fb;

    // Eight bit-serial iterations unrolled; reflected form shifts right and eats the LSB first.
    always_comb begin
        w_c  = acc;
        w_fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (reflect) begin
                w_fb = w_c[0] ^ d[i];
                w_c  = w_c >> 1;
                if (w_fb) w_c = w_c ^ POLY_REFL;
            end else begin
                w_fb = w_c[31] ^ d[7-i];
                w_c  = w_c << 1;
                if (w_fb) w_c = w_c ^ POLY;
            end
        end
        nxt = w_c;
    end

endmodule

// File: rtl/crc2.sv
// rtl/crc2.sv - byte-serial CRC-32 engine, IEEE 802.3 (reflected) or MPEG-2 (normal) per crc_mode
module crc2
    import crc2_pkg::*;
#(
    parameter logic [31:0] POLY   = CRC_POLY_NORM,
    parameter logic [31:0] INIT   = CRC_INIT,
    parameter logic [31:0] XOROUT = CRC_XOROUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clc,
    input  logic        crc_mode,
    input  logic        crc_en,
    input  logic [7:0]  d_in,
    output logic [31:0] crc_out
);

    crc_mode_e   w_mode;
    logic [31:0] w_nxt;
    logic [31:0] r_acc;

    assign w_mode = crc_mode_e'(crc_mode);

    crc32_byte_step #(
        .POLY (POLY)
    ) u_step (
        .acc     (r_acc),
        .d       (d_in),
        .reflect (w_mode == CRC_IEEE_REFL),
        .nxt     (w_nxt)
    );

    // Clear wins over a concurrent byte so a new message never inherits the dropped byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= INIT;
        end else if (clc) begin
            r_acc <= INIT;
        end else if (crc_en) begin
            r_acc <= w_nxt;
        end
    end

    assign crc_out = (w_mode == CRC_IEEE_REFL) ? (r_acc ^ XOROUT) : r_acc;

endmodule

// File: tb/tb_crc2.sv
// tb/tb_crc2.sv - directed self-checking bench for crc2 with known CRC-32 check values
module tb_crc2;

    logic        clk;
    logic        rst_n;
    logic        clc;
    logic        crc_mode;
    logic        crc_en;
    logic [7:0]  d_in;
    logic [31:0] crc_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc2 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clc      (clc),
        .crc_mode (crc_mode),
        .crc_en   (crc_en),
        .d_in     (d_in),
        .crc_out  (crc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [7:0] b);
        d_in   = b;
        crc_en = 1'b1;
        @(negedge clk);
        crc_en = 1'b0;
    endtask

    task automatic feed_range(input int first, input int last);
        for (int i = first; i <= last; i++) feed(msg[i]);
    endtask

    task automatic pulse_clc();
        clc = 1'b1;
        @(negedge clk);
        clc = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b1;
        clc      = 1'b0;
        crc_mode = 1'b0;
        crc_en   = 1'b0;
        d_in     = 8'h00;

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_mode0", crc_out, 32'h00000000);
        crc_mode = 1'b1;
        #1 check("reset_mode1", crc_out, 32'hFFFFFFFF);
        @(negedge clk);
        crc_mode = 1'b0;
        rst_n    = 1'b1;

        feed_range(0, 8);
        check("ieee_123456789", crc_out, 32'hCBF43926);
        repeat (3) @(negedge clk);
        check("ieee_held", crc_out, 32'hCBF43926);

        pulse_clc();
        feed(8'h61);
        check("ieee_a", crc_out, 32'hE8B7BE43);

        pulse_clc();
        feed_range(0, 3);
        check("gap_prefix_1234", crc_out, 32'h9BE3E0A3);
        d_in = 8'hA5;
        @(negedge clk);
        d_in = 8'hxx;
        @(negedge clk);
        d_in = 8'h00;
        @(negedge clk);
        check("gap_hold", crc_out, 32'h9BE3E0A3);
        feed_range(4, 8);
        check("gap_full", crc_out, 32'hCBF43926);

        crc_mode = 1'b1;
        pulse_clc();
        check("mpeg_clear", crc_out, 32'hFFFFFFFF);
        feed_range(0, 8);
        check("mpeg_123456789", crc_out, 32'h0376E6E7);
        clc    = 1'b1;
        crc_en = 1'b1;
        d_in   = 8'h31;
        @(negedge clk);
        clc    = 1'b0;
        crc_en = 1'b0;
        check("clc_over_en", crc_out, 32'hFFFFFFFF);

        crc_mode = 1'b0;
        pulse_clc();
        repeat (4) feed(8'h61);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset", crc_out, 32'h00000000);
        rst_n = 1'b1;
        feed_range(0, 8);
        check("after_reset_123456789", crc_out, 32'hCBF43926);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
